// File: rtl/serial_add_ctrl_if.sv
// Handshake/operand bundle and full-adder cell hookup for serial_add_ctrl.
// Defining SERIAL_ADD_OVF_EN adds the OV (two's-complement overflow) signal.
interface serial_add_ctrl_if #(
    parameter int unsigned WIDTH = 4
);
    logic             START;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CI;
    logic             READY;
    logic             FA_A;
    logic             FA_B;
    logic             FA_CI;
    logic             FA_S;
    logic             FA_CO;
    logic [WIDTH-1:0] S;
    logic             CO;
    logic             VALID;
    logic             ACK;
`ifdef SERIAL_ADD_OVF_EN
    logic             OV;
`endif

    // slave: the controller; master: requester/consumer plus the adder cell
    modport slave (
        input  START, A, B, CI, FA_S, FA_CO, ACK,
`ifdef SERIAL_ADD_OVF_EN
        output OV,
`endif
        output READY, FA_A, FA_B, FA_CI, S, CO, VALID
    );

    modport master (
        output START, A, B, CI, FA_S, FA_CO, ACK,
`ifdef SERIAL_ADD_OVF_EN
        input  OV,
`endif
        input  READY, FA_A, FA_B, FA_CI, S, CO, VALID
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: feeds an external full-adder cell LSB first, one bit per clock.
// Optional SERIAL_ADD_OVF_EN macro adds the registered OV overflow output.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input logic           CLK,
    input logic           RST,
    serial_add_ctrl_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic             carry;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] s_q;
    logic             co_q;
    logic             ready_q;
    logic             valid_q;
    logic             last;
`ifdef SERIAL_ADD_OVF_EN
    logic             ov_q;
`endif

    assign last = (count == CW'(WIDTH - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            count   <= '0;
            carry   <= 1'b0;
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ov_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.START) begin
                        a_sh    <= bus.A;
                        b_sh    <= bus.B;
                        carry   <= bus.CI;
                        count   <= '0;
                        sum_sh  <= '0;
                        ready_q <= 1'b0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    sum_sh <= {bus.FA_S, sum_sh[WIDTH-1:1]};
                    carry  <= bus.FA_CO;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    if (last) begin
                        // count parks at zero so it never runs past WIDTH-1
                        count   <= '0;
                        s_q     <= {bus.FA_S, sum_sh[WIDTH-1:1]};
                        co_q    <= bus.FA_CO;
`ifdef SERIAL_ADD_OVF_EN
                        ov_q    <= carry ^ bus.FA_CO;
`endif
                        valid_q <= 1'b1;
                        state   <= DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.ACK) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.FA_A  = 1'b0;
        bus.FA_B  = 1'b0;
        bus.FA_CI = 1'b0;
        if (state == RUN) begin
            bus.FA_A  = a_sh[0];
            bus.FA_B  = b_sh[0];
            bus.FA_CI = carry;
        end
    end

    assign bus.READY = ready_q;
    assign bus.VALID = valid_q;
    assign bus.S     = s_q;
    assign bus.CO    = co_q;
`ifdef SERIAL_ADD_OVF_EN
    assign bus.OV    = ov_q;
`endif
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=4) with a behavioural full-adder cell.
// Expected {CO,S,OV} come from integer arithmetic on the operands; a monitor checks each result.
module tb_serial_add_ctrl;
    localparam int unsigned WIDTH = 4;

    typedef struct {
        logic [3:0] s;
        logic       co;
        logic       ov;
        int         edge_no;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    logic vprev = 1'b0;

    serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    assign bus.FA_S  = bus.FA_A ^ bus.FA_B ^ bus.FA_CI;
    assign bus.FA_CO = (bus.FA_A & bus.FA_B) | (bus.FA_A & bus.FA_CI) | (bus.FA_B & bus.FA_CI);

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every rising VALID must match the oldest outstanding expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (bus.VALID && !vprev) begin
                if (q.size() == 0) begin
                    check("unexpected_valid", 32'(bus.VALID), 32'd0);
                end else begin
                    e = q.pop_front();
                    check("sum", 32'(bus.S), 32'(e.s));
                    check("carry_out", 32'(bus.CO), 32'(e.co));
`ifdef SERIAL_ADD_OVF_EN
                    check("overflow", 32'(bus.OV), 32'(e.ov));
`endif
                    check("latency_edge", 32'(cyc), 32'(e.edge_no));
                end
            end
            vprev = bus.VALID;
        end
    end

    logic [3:0] last_s;

    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic ci,
                         input int hold, input bit restart);
        int   n;
        int   total;
        int   sr;
        exp_t e;
        n = 0;
        @(negedge CLK);
        while (!bus.READY && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check("ready_before_start", 32'(bus.READY), 32'd1);
        bus.START = 1'b1;
        bus.A = a;
        bus.B = b;
        bus.CI = ci;
        total = int'(a) + int'(b) + int'(ci);
        sr = int'($signed(a)) + int'($signed(b)) + int'(ci);
        e.s = total[3:0];
        e.co = total[4];
        e.ov = (sr > 7) || (sr < -8);
        e.edge_no = cyc + 1 + WIDTH;
        q.push_back(e);
        last_s = e.s;
        @(negedge CLK);
        check("ready_in_run", 32'(bus.READY), 32'd0);
        if (restart) begin
            bus.START = 1'b1;
            bus.A = 4'h3;
            bus.B = 4'($urandom);
        end else begin
            bus.START = 1'b0;
            bus.A = 4'($urandom);
            bus.B = 4'($urandom);
        end
        bus.CI = 1'($urandom);
        @(negedge CLK);
        bus.START = 1'b0;
        n = 0;
        while (!bus.VALID && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("valid_arrives", 32'(bus.VALID), 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            check("valid_held", 32'(bus.VALID), 32'd1);
            check("sum_held", 32'(bus.S), 32'(e.s));
            check("ready_in_done", 32'(bus.READY), 32'd0);
        end
        bus.ACK = 1'b1;
        @(negedge CLK);
        bus.ACK = 1'b0;
        check("ready_after_ack", 32'(bus.READY), 32'd1);
        check("valid_after_ack", 32'(bus.VALID), 32'd0);
        check("sum_after_ack", 32'(bus.S), 32'(last_s));
    endtask

    initial begin
        bus.START = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.CI = 1'b0;
        bus.ACK = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        check("reset_ready", 32'(bus.READY), 32'd1);
        check("reset_valid", 32'(bus.VALID), 32'd0);
        check("reset_sum", 32'(bus.S), 32'd0);
        check("reset_co", 32'(bus.CO), 32'd0);
        check("reset_fa_a", 32'(bus.FA_A), 32'd0);

        do_op(4'h7, 4'h1, 1'b0, 2, 1'b0);
        do_op(4'hF, 4'h1, 1'b0, 0, 1'b0);
        do_op(4'h0, 4'h0, 1'b1, 1, 1'b0);
        do_op(4'h5, 4'h6, 1'b0, 1, 1'b1);
        do_op(4'h8, 4'h8, 1'b0, 0, 1'b0);
        do_op(4'hF, 4'hF, 1'b1, 0, 1'b0);

        // Abort: reset lands on the edge where count==2; no result may appear
        @(negedge CLK);
        bus.START = 1'b1;
        bus.A = 4'hC;
        bus.B = 4'h7;
        bus.CI = 1'b1;
        @(negedge CLK);
        bus.START = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("abort_ready", 32'(bus.READY), 32'd1);
        check("abort_valid", 32'(bus.VALID), 32'd0);
        check("abort_sum", 32'(bus.S), 32'd0);
        check("abort_co", 32'(bus.CO), 32'd0);
        last_s = 4'h0;
        repeat (6) @(negedge CLK);
        check("abort_no_valid", 32'(bus.VALID), 32'd0);
        do_op(4'h9, 4'h9, 1'b0, 0, 1'b0);

        do_op(4'h2, 4'h4, 1'b0, 10, 1'b0);

        // ACK while idle must be ignored
        @(negedge CLK);
        bus.ACK = 1'b1;
        @(negedge CLK);
        bus.ACK = 1'b0;
        check("idle_ack_ready", 32'(bus.READY), 32'd1);
        check("idle_ack_sum", 32'(bus.S), 32'(last_s));

        for (int k = 0; k < 30; k++) begin
            do_op(4'($urandom), 4'($urandom), 1'($urandom),
                  int'($urandom_range(0, 3)), 1'($urandom));
        end

        repeat (4) @(negedge CLK);
        check("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation ran past its time limit");
        $fatal(1);
    end
endmodule
